// File: rtl/alu_mem_engine_pkg.sv
// Shared types for the operand-memory / ALU sequencer: opcodes, FSM states
// and the packed command-entry layout {a, b, oper}.
package alu_mem_pkg;

  localparam int CMD_DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } oper_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Reference layout of one command entry; the engine stores the same
  // {a, b, oper} ordering at its own DATA_WIDTH.
  typedef struct packed {
    logic [CMD_DATA_W-1:0] a;
    logic [CMD_DATA_W-1:0] b;
    oper_e                 oper;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_mem_engine_alu_core.sv
// Combinational 2W-wide ALU. Operands are unsigned; SUB is computed at full
// result width so the difference comes out sign-extended two's complement.
module alu_core
  import alu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic [2:0]              oper_i,
  output logic [2*DATA_WIDTH-1:0] res_o
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam int SW = $clog2(RW);

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [SW-1:0] sh;

  assign a_ext = {{DATA_WIDTH{1'b0}}, a_i};
  assign b_ext = {{DATA_WIDTH{1'b0}}, b_i};
  assign sh    = b_i[SW-1:0];

  // Select the operation result for the current opcode.
  always_comb begin
    res_o = '0;
    case (oper_e'(oper_i))
      OP_ADD:  res_o = a_ext + b_ext;
      OP_SUB:  res_o = a_ext - b_ext;
      OP_MUL:  res_o = a_ext * b_ext;
      OP_AND:  res_o = a_ext & b_ext;
      OP_OR:   res_o = a_ext | b_ext;
      OP_XOR:  res_o = a_ext ^ b_ext;
      OP_SHL:  res_o = a_ext << sh;
      OP_SHR:  res_o = a_ext >> sh;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mem_engine.sv
// Command memory -> registered read -> ALU -> FWFT result FIFO, sequenced by
// a small FSM. Reads are only issued when the FIFO plus in-flight stages
// still has room, so the pipeline never stalls and the FIFO never overflows.
module alu_mem_engine
  import alu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_a,
  input  logic [DATA_WIDTH-1:0]      wr_b,
  input  logic [2:0]                 wr_oper,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   start_addr,
  input  logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*DATA_WIDTH-1:0]    res_out,
  output logic [$clog2(DEPTH)-1:0]   out_idx
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int RW  = 2 * DATA_WIDTH;
  localparam int EW  = 2 * DATA_WIDTH + 3;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int FCW = FAW + 1;
  localparam int OW  = FCW + 1;

  // Control state
  state_e         state_q;
  logic [AW-1:0]  addr_q;
  logic [CW-1:0]  rem_q;
  logic           done_q;
  logic           vld_p0_q;
  logic           vld_p1_q;
  logic [FAW-1:0] wr_ptr_q;
  logic [FAW-1:0] rd_ptr_q;
  logic [FCW-1:0] cnt_q;
  logic [FCW-1:0] cnt_d;

  // Datapath state (not reset)
  logic [EW-1:0]  mem_q      [DEPTH];
  logic [AW-1:0]  addr_p0_q;
  logic [EW-1:0]  cmd_p1_q;
  logic [AW-1:0]  idx_p1_q;
  logic [RW-1:0]  fifo_res_q [FIFO_DEPTH];
  logic [AW-1:0]  fifo_idx_q [FIFO_DEPTH];

  logic [RW-1:0]  alu_res;
  logic [OW-1:0]  occ;
  logic           issue;
  logic           push;
  logic           pop;
  logic           drain_done;

  assign occ = {1'b0, cnt_q} + OW'(vld_p0_q) + OW'(vld_p1_q);
  assign issue = (state_q == RUN) && (occ < OW'(FIFO_DEPTH));
  assign push = vld_p1_q;
  assign pop = out_valid && out_ready;
  assign drain_done = !vld_p0_q && !vld_p1_q &&
                      ((cnt_q == '0) || ((cnt_q == FCW'(1)) && pop));

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = (cnt_q != '0);
  assign res_out   = out_valid ? fifo_res_q[rd_ptr_q] : '0;
  assign out_idx   = out_valid ? fifo_idx_q[rd_ptr_q] : '0;

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i    (cmd_p1_q[EW-1 -: DATA_WIDTH]),
    .b_i    (cmd_p1_q[EW-DATA_WIDTH-1 -: DATA_WIDTH]),
    .oper_i (cmd_p1_q[2:0]),
    .res_o  (alu_res)
  );

  // Command memory: synchronous write, survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= {wr_a, wr_b, wr_oper};
  end

  // Stage p0 -> p1: address capture, then read-first memory fetch.
  always_ff @(posedge clk) begin
    if (issue) addr_p0_q <= addr_q;
    cmd_p1_q <= mem_q[addr_p0_q];
    idx_p1_q <= addr_p0_q;
  end

  // Stage p1 -> FIFO: registered ALU result and its source address.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_res_q[wr_ptr_q] <= alu_res;
      fifo_idx_q[wr_ptr_q] <= idx_p1_q;
    end
  end

  // FIFO occupancy next-state; simultaneous push and pop cancel out.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + FCW'(1);
      2'b01:   cnt_d = cnt_q - FCW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FAW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FAW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Run sequencer: issue reads under credit, drain, then pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      vld_p0_q <= issue;
      vld_p1_q <= vld_p0_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= start_addr;
            rem_q   <= count;
            state_q <= (count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            addr_q <= addr_q + AW'(1);
            rem_q  <= rem_q - CW'(1);
            if (rem_q == CW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mem_engine.sv
// Directed bench for alu_mem_engine: latency, opcodes, back-pressure,
// wrap-around, mid-run reset, ignored start and zero-count runs.
module tb_alu_mem_engine;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_a;
  logic [7:0]  wr_b;
  logic [2:0]  wr_oper;
  logic        start;
  logic [3:0]  start_addr;
  logic [4:0]  count;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res_out;
  logic [3:0]  out_idx;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_res [16];
  logic [31:0] exp_idx [16];

  alu_mem_engine #(.DATA_WIDTH(8), .DEPTH(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_a       (wr_a),
    .wr_b       (wr_b),
    .wr_oper    (wr_oper),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res_out    (res_out),
    .out_idx    (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [3:0] addr, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] op);
    wr_en = 1'b1; wr_addr = addr; wr_a = a; wr_b = b; wr_oper = op;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] addr, input logic [4:0] cnt);
    start = 1'b1; start_addr = addr; count = cnt;
    tick();
    start = 1'b0;
  endtask

  // Accept results until done, comparing the first n against exp_res/exp_idx.
  task automatic collect(input int n, input string tag);
    int k;
    bit seen_done;
    k = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      if (done) seen_done = 1'b1;
      else begin
        if (out_valid) begin
          if (k < n) begin
            check({tag, "_res"}, 32'(res_out), exp_res[k]);
            check({tag, "_idx"}, 32'(out_idx), exp_idx[k]);
          end
          k++;
        end
        tick();
      end
    end
    check({tag, "_count"}, 32'(k), 32'(n));
    check({tag, "_done"}, 32'(seen_done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; wr_oper = '0;
    start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_res",   32'(res_out),   32'd0);
    check("rst_idx",   32'(out_idx),   32'd0);

    // Single ADD: latency and done timing
    write_mem(4'd0, 8'd200, 8'd100, 3'd0);
    out_ready = 1'b1;
    start_run(4'd0, 5'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick(); tick();
    check("t1_valid_e2", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid_e3", 32'(out_valid), 32'd1);
    check("t1_res", 32'(res_out), 32'h012C);
    check("t1_idx", 32'(out_idx), 32'd0);
    tick();
    check("t1_valid_e4", 32'(out_valid), 32'd0);
    check("t1_done_e4", 32'(done), 32'd0);
    tick();
    check("t1_done_e5", 32'(done), 32'd1);
    check("t1_busy_e5", 32'(busy), 32'd0);
    tick();
    check("t1_done_e6", 32'(done), 32'd0);

    // SUB then MUL on consecutive cycles
    write_mem(4'd2, 8'd5, 8'd7, 3'd1);
    write_mem(4'd3, 8'd255, 8'd255, 3'd2);
    start_run(4'd2, 5'd2);
    tick(); tick(); tick();
    check("t2_valid0", 32'(out_valid), 32'd1);
    check("t2_res0", 32'(res_out), 32'hFFFE);
    check("t2_idx0", 32'(out_idx), 32'd2);
    tick();
    check("t2_valid1", 32'(out_valid), 32'd1);
    check("t2_res1", 32'(res_out), 32'hFE01);
    check("t2_idx1", 32'(out_idx), 32'd3);
    tick();
    check("t2_valid2", 32'(out_valid), 32'd0);
    tick();
    check("t2_done", 32'(done), 32'd1);
    tick();

    // Back-pressure: 8 ADDs with consumer stalled, late write to an unread entry
    for (int i = 0; i < 8; i++) begin
      write_mem(4'(4 + i), 8'(i * 10), 8'(i + 1), 3'd0);
      exp_res[i] = 32'(i * 11 + 1);
      exp_idx[i] = 32'(4 + i);
    end
    out_ready = 1'b0;
    start_run(4'd4, 5'd8);
    for (int i = 0; i < 8; i++) tick();
    check("t3_valid_stall", 32'(out_valid), 32'd1);
    check("t3_head_res", 32'(res_out), 32'd1);
    check("t3_head_idx", 32'(out_idx), 32'd4);
    check("t3_busy_stall", 32'(busy), 32'd1);
    write_mem(4'd11, 8'd100, 8'd50, 3'd0);
    exp_res[7] = 32'h96;
    check("t3_head_hold", 32'(res_out), 32'd1);
    out_ready = 1'b1;
    collect(8, "t3");

    // Address wrap: 14, 15, 0, 1
    write_mem(4'd14, 8'd1, 8'd2, 3'd5);
    write_mem(4'd15, 8'hF0, 8'h0F, 3'd4);
    write_mem(4'd1, 8'd3, 8'd4, 3'd6);
    exp_res[0] = 32'h3;   exp_idx[0] = 32'd14;
    exp_res[1] = 32'hFF;  exp_idx[1] = 32'd15;
    exp_res[2] = 32'h12C; exp_idx[2] = 32'd0;
    exp_res[3] = 32'h30;  exp_idx[3] = 32'd1;
    start_run(4'd14, 5'd4);
    collect(4, "t4");

    // Mid-run reset, then rerun from unchanged memory
    write_mem(4'd12, 8'hC3, 8'h5A, 3'd3);
    write_mem(4'd13, 8'h80, 8'd3, 3'd7);
    out_ready = 1'b0;
    start_run(4'd12, 5'd6);
    tick(); tick(); tick(); tick();
    check("t5_valid_pre", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_busy_rst",  32'(busy),      32'd0);
    check("t5_valid_rst", 32'(out_valid), 32'd0);
    check("t5_res_rst",   32'(res_out),   32'd0);
    check("t5_idx_rst",   32'(out_idx),   32'd0);
    #2 reset = 1'b0;
    tick();
    out_ready = 1'b1;
    exp_res[0] = 32'h42;  exp_idx[0] = 32'd12;
    exp_res[1] = 32'h10;  exp_idx[1] = 32'd13;
    exp_res[2] = 32'h3;   exp_idx[2] = 32'd14;
    exp_res[3] = 32'hFF;  exp_idx[3] = 32'd15;
    exp_res[4] = 32'h12C; exp_idx[4] = 32'd0;
    exp_res[5] = 32'h30;  exp_idx[5] = 32'd1;
    start_run(4'd12, 5'd6);
    collect(6, "t5");

    // Start while busy is ignored
    exp_res[0] = 32'hFFFE; exp_idx[0] = 32'd2;
    exp_res[1] = 32'hFE01; exp_idx[1] = 32'd3;
    start_run(4'd2, 5'd2);
    start = 1'b1; start_addr = 4'd4; count = 5'd8;
    tick();
    start = 1'b0;
    collect(2, "t6");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_extra", 32'(out_valid), 32'd0);
    end

    // Zero-count run
    start_run(4'd0, 5'd0);
    check("t7_done_e0", 32'(done), 32'd0);
    check("t7_busy_e0", 32'(busy), 32'd1);
    tick();
    check("t7_done_e1", 32'(done), 32'd1);
    check("t7_valid_e1", 32'(out_valid), 32'd0);
    tick();
    check("t7_done_e2", 32'(done), 32'd0);
    check("t7_busy_e2", 32'(busy), 32'd0);
    check("t7_valid_e2", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mem_engine.md
# alu_mem_engine

Parametrised operand-memory plus ALU sequencer: the successor to the fixed mem-to-ALU pairing in the top level. A host preloads a command memory of {A, B, oper} entries, then issues a start with a base address and count. The engine streams the entries through a registered ALU and a result FIFO, returning each result through a valid/ready handshake. It sits between the host/testbench command port and any downstream consumer of `res_out`.

## Interface
- `DATA_WIDTH`, 8: operand width; results are 2*DATA_WIDTH.
- `DEPTH`, 16: command memory entries (power of two, ≥2).
- `FIFO_DEPTH`, 4: result FIFO entries (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write one command entry.
- `wr_addr`  in  $clog2(DEPTH)  entry address.
- `wr_a`, `wr_b`  in  DATA_WIDTH  operands.
- `wr_oper`  in  3  opcode.
- `start`  in  1  begin a run; sampled only in IDLE.
- `start_addr`  in  $clog2(DEPTH)  first entry of the run.
- `count`  in  $clog2(DEPTH)+1  number of entries to process.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at end of run.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `res_out`  out  2*DATA_WIDTH  result.
- `out_idx`  out  $clog2(DEPTH)  memory address that produced `res_out`.

## Operation
- Opcodes, with A and B unsigned and the result 2W wide:
  - 0 ADD: zero-extended A+B, carry kept.
  - 1 SUB: A−B in two's complement, sign-extended to 2W.
  - 2 MUL: unsigned A*B.
  - 3 AND, 4 OR, 5 XOR: zero-extended.
  - 6 SHL: zext(A) << B[$clog2(2W)-1:0].
  - 7 SHR: zext(A) >> B[$clog2(2W)-1:0].
- Memory:
  - Synchronous write.
  - Synchronous read-first: a same-cycle write to the address being read returns old data.
  - Not cleared by reset.
- FSM:
  - IDLE: on `start`, latch `start_addr` and `count`. If count == 0, go to DONE; else go to RUN.
  - RUN: issue one read per cycle when the credit allows. Address increments modulo DEPTH (wraps). When `count` reads have been issued, go to DRAIN.
  - DRAIN: wait until the pipeline and FIFO are empty and the last result has been accepted, then go to DONE.
  - DONE: `done` is high for one cycle, then go to IDLE.
- Credit rule: issue a read only while FIFO occupancy + in-flight < FIFO_DEPTH. The FIFO never overflows and the ALU pipeline never stalls internally.
- `count` > DEPTH is legal; addresses wrap and entries are re-read.
- `start` outside IDLE is ignored.
- Writes are permitted during a run; entries not yet read return the new data.
- Results leave in issue order.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `out_valid` = 0, `res_out` = 0, `out_idx` = 0.
  - FSM = IDLE.
  - FIFO empty; in-flight count = 0.
- Pipeline:
  - Read address registered at the edge after `start` (E0+1).
  - Memory data registered at E0+2.
  - ALU result pushed into the FIFO at E0+3.
  - `out_valid` is high after E0+3 (first-word-fall-through).
- Throughput: one result per cycle while `out_ready` is held high.
- Handshake: a transfer occurs on an edge where `out_valid && out_ready`. `res_out` and `out_idx` hold stable while `out_valid && !out_ready`.
- `done` rises the cycle after the final transfer. With count == 0, `done` is high after E0+1 and `out_valid` is never raised.
- FIFO push and pop in the same cycle leave occupancy unchanged. Pop and push while full is permitted.
- An asynchronous reset mid-run:
  - Aborts immediately: outputs return to their reset values and pending results are discarded.
  - Memory contents survive.

## Structure
- Package `alu_mem_pkg`:
  - `oper_e` enum (3-bit opcodes above).
  - `state_e` enum {IDLE, RUN, DRAIN, DONE}.
  - `cmd_t` struct {a, b, oper}, parametrised through a localparam width.
- Sub-module `alu_core`: combinational 2W-wide compute from {a, b, oper}. The engine registers its output.
- FIFO and FSM are inline in `alu_mem_engine`.

## Test plan
- Write addr 0 {A=200, B=100, ADD}; start addr 0, count 1, `out_ready`=1 → `res_out`=0x012C, `out_idx`=0 after E0+3; `done` the next cycle.
- Write {5, 7, SUB} and {255, 255, MUL}; run count 2 → 0xFFFE, then 0xFE01, on consecutive cycles.
- Load 8 ADD entries; count 8, `out_ready`=0 → exactly 4 results buffered and issue stalls; raise `out_ready` → all 8 results in order, none lost or duplicated.
- `start_addr`=14, count 4 → `out_idx` sequence 14, 15, 0, 1.
- Assert `reset` mid-run → `busy`/`out_valid` = 0 at once; rerun without rewriting the memory → same results as before.
- `start` while busy → ignored, with no extra results. count 0 → `done` after E0+1, `out_valid` stays 0.
